// File: rtl/riscv32i_dmem_responder_if.sv
// riscv32i_dmem_responder_if: request/response channels between core and data memory
interface riscv32i_dmem_responder_if #(
    parameter int AW = 32
);
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic [3:0]    req_be;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/riscv32i_dmem_responder.sv
// riscv32i_dmem_responder: wait-stated, byte-enabled data-memory responder with valid/ready channels
module riscv32i_dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1,
    parameter int AW          = 32
) (
    input  logic                        clk,
    input  logic                        reset_n,
    riscv32i_dmem_responder_if.slave    bus,
    output logic                        busy
);
    localparam int IW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          lat_write;
    logic [AW-1:0] lat_addr;
    logic [31:0]   lat_wdata;
    logic [3:0]    lat_be;
    logic          accept, enter_resp, op_write, op_err;
    logic [AW-1:0] op_addr;
    logic [31:0]   op_wdata;
    logic [3:0]    op_be;
    logic [IW-1:0] op_idx;
    logic [31:0]   rdata_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH_WORDS];

    assign bus.req_ready = (state == IDLE) && reset_n;
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
    assign busy          = (state != IDLE);

    // Next state and wait counter; with zero latency the accepting edge itself enters RESP, so the operation uses the live request fields
    always_comb begin
        accept     = bus.req_valid && bus.req_ready;
        state_nx   = state;
        cnt_nx     = cnt;
        enter_resp = 1'b0;
        case (state)
            IDLE: if (accept) begin
                if (LATENCY == 0) begin
                    state_nx   = RESP;
                    enter_resp = 1'b1;
                end else begin
                    state_nx = WAIT;
                    cnt_nx   = LAT_M1;
                end
            end
            WAIT: if (cnt == 4'd0) begin
                state_nx   = RESP;
                enter_resp = 1'b1;
            end else begin
                cnt_nx = cnt - 4'd1;
            end
            RESP: if (bus.rsp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        op_write = (state == IDLE) ? bus.req_write : lat_write;
        op_addr  = (state == IDLE) ? bus.req_addr  : lat_addr;
        op_wdata = (state == IDLE) ? bus.req_wdata : lat_wdata;
        op_be    = (state == IDLE) ? bus.req_be    : lat_be;
        op_idx   = op_addr[IW+1:2];
        op_err   = (op_addr[1:0] != 2'b00) || ((op_addr >> (IW + 2)) != '0);
    end

    // Control state, latched request and registered response; request fields are captured only on acceptance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'd0;
            lat_be    <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                lat_write <= bus.req_write;
                lat_addr  <= bus.req_addr;
                lat_wdata <= bus.req_wdata;
                lat_be    <= bus.req_be;
            end
            if (enter_resp) begin
                err_q   <= op_err;
                rdata_q <= (op_err || op_write) ? 32'd0 : mem[op_idx];
            end else if (state == RESP && bus.rsp_ready) begin
                err_q   <= 1'b0;
                rdata_q <= 32'd0;
            end
        end
    end

    // Byte-lane store commit on the edge that enters RESP; the array itself is never reset
    always_ff @(posedge clk) begin
        if (enter_resp && op_write && !op_err)
            for (int i = 0; i < 4; i++)
                if (op_be[i]) mem[op_idx][8*i +: 8] <= op_wdata[8*i +: 8];
    end
endmodule

// File: tb/tb_riscv32i_dmem_responder.sv
// tb_riscv32i_dmem_responder: directed checks of latency, byte enables, errors, backpressure and reset
module tb_riscv32i_dmem_responder;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic busy0, busy1, busy3;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(negedge clk) cyc++;

    riscv32i_dmem_responder_if #(.AW(32)) d0();
    riscv32i_dmem_responder_if #(.AW(32)) d1();
    riscv32i_dmem_responder_if #(.AW(32)) d3();

    riscv32i_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(0), .AW(32)) u0 (.clk(clk), .reset_n(reset_n), .bus(d0), .busy(busy0));
    riscv32i_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .AW(32)) u1 (.clk(clk), .reset_n(reset_n), .bus(d1), .busy(busy1));
    riscv32i_dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3), .AW(32)) u3 (.clk(clk), .reset_n(reset_n), .bus(d3), .busy(busy3));

    virtual riscv32i_dmem_responder_if #(.AW(32)) vif;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic txn(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic er, output int lat);
        int n;
        @(negedge clk);
        vif.rsp_ready = 1'b1;
        vif.req_valid = 1'b1;
        vif.req_write = wr;
        vif.req_addr  = a;
        vif.req_wdata = wd;
        vif.req_be    = be;
        n = 0;
        while (!vif.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        vif.req_valid = 1'b0;
        vif.req_write = 1'($urandom());
        vif.req_addr  = $urandom();
        vif.req_wdata = $urandom();
        vif.req_be    = 4'($urandom());
        lat = 0;
        @(negedge clk);
        while (!vif.rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        rd = vif.rsp_rdata;
        er = vif.rsp_err;
        @(posedge clk);
        #1;
    endtask

    task automatic b2b(input int lat_exp);
        logic [31:0] got [3];
        int acc [3];
        int nr, n;
        nr = 0;
        for (int i = 0; i < 3; i++) got[i] = 32'd0;
        vif.rsp_ready = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            vif.req_valid = 1'b1;
            vif.req_write = 1'b0;
            vif.req_addr  = 32'h40 + 32'(4 * i);
            n = 0;
            while (!vif.req_ready && n < 50) begin
                if (vif.rsp_valid && nr < 3) got[nr++] = vif.rsp_rdata;
                @(negedge clk);
                n++;
            end
            acc[i] = cyc;
            @(posedge clk);
            @(negedge clk);
        end
        vif.req_valid = 1'b0;
        n = 0;
        while (!vif.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (nr < 3) got[nr++] = vif.rsp_rdata;
        @(posedge clk);
        #1;
        check($sformatf("b2b%0d_gap1", lat_exp), 32'(acc[1] - acc[0]), 32'(lat_exp + 2));
        check($sformatf("b2b%0d_gap2", lat_exp), 32'(acc[2] - acc[1]), 32'(lat_exp + 2));
        check($sformatf("b2b%0d_count", lat_exp), 32'(nr), 32'd3);
        for (int i = 0; i < 3; i++)
            check($sformatf("b2b%0d_data%0d", lat_exp, i), got[i], 32'hA000_0000 | 32'(lat_exp << 8) | 32'(i));
    endtask

    initial begin
        #500000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd, r0;
        logic er;
        int lat, n, hits;
        d0.req_valid = 0; d0.req_write = 0; d0.req_addr = 0; d0.req_wdata = 0; d0.req_be = 0; d0.rsp_ready = 0;
        d1.req_valid = 0; d1.req_write = 0; d1.req_addr = 0; d1.req_wdata = 0; d1.req_be = 0; d1.rsp_ready = 0;
        d3.req_valid = 0; d3.req_write = 0; d3.req_addr = 0; d3.req_wdata = 0; d3.req_be = 0; d3.rsp_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 32'(d1.rsp_valid), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_rdata", d1.rsp_rdata, 32'd0);
        check("rst_err", 32'(d1.rsp_err), 32'd0);
        reset_n = 1'b1;
        #1;
        check("rst_req_ready", 32'(d1.req_ready), 32'd1);

        vif = d1;
        txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, lat);
        check("st10_lat", 32'(lat), 32'd1);
        check("st10_err", 32'(er), 32'd0);
        check("st10_rdata", rd, 32'd0);
        txn(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        check("ld10_rdata", rd, 32'hDEADBEEF);
        check("ld10_err", 32'(er), 32'd0);

        txn(1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, lat);
        txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, lat);
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("be0101_rdata", rd, 32'h11BB33DD);
        txn(1'b1, 32'h20, 32'hFFFFFFFF, 4'b0000, rd, er, lat);
        check("be0000_err", 32'(er), 32'd0);
        txn(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        check("be0000_keep", rd, 32'h11BB33DD);

        txn(1'b0, 32'h22, 32'h0, 4'h0, rd, er, lat);
        check("mis_err", 32'(er), 32'd1);
        check("mis_rdata", rd, 32'd0);
        txn(1'b1, 32'h0, 32'h0BADF00D, 4'hF, rd, er, lat);
        txn(1'b1, 32'h400, 32'h55555555, 4'hF, rd, er, lat);
        check("oor_st_err", 32'(er), 32'd1);
        txn(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        check("oor_word0", rd, 32'h0BADF00D);
        txn(1'b1, 32'h3FC, 32'h12345678, 4'hF, rd, er, lat);
        check("top_st_err", 32'(er), 32'd0);
        txn(1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, lat);
        check("top_ld", rd, 32'h12345678);
        txn(1'b0, 32'h8000_0000, 32'h0, 4'h0, rd, er, lat);
        check("hi_err", 32'(er), 32'd1);

        @(negedge clk);
        d1.rsp_ready = 1'b0;
        d1.req_valid = 1'b1;
        d1.req_write = 1'b0;
        d1.req_addr  = 32'h10;
        check("bp_ready0", 32'(d1.req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        d1.req_addr = 32'h20;
        n = 0;
        while (!d1.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        r0 = d1.rsp_rdata;
        check("bp_first", r0, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp_valid%0d", k), 32'(d1.rsp_valid), 32'd1);
            check($sformatf("bp_rdata%0d", k), d1.rsp_rdata, 32'hDEADBEEF);
            check($sformatf("bp_rready%0d", k), 32'(d1.req_ready), 32'd0);
        end
        d1.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_idle_ready", 32'(d1.req_ready), 32'd1);
        check("bp_idle_valid", 32'(d1.rsp_valid), 32'd0);
        @(posedge clk);
        @(negedge clk);
        d1.req_valid = 1'b0;
        check("bp_second_busy", 32'(busy1), 32'd1);
        n = 0;
        while (!d1.rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_second_data", d1.rsp_rdata, 32'h11BB33DD);
        @(posedge clk);
        @(negedge clk);
        check("bp_no_dup", 32'(busy1), 32'd0);

        vif = d0;
        for (int i = 0; i < 3; i++) begin
            txn(1'b1, 32'h40 + 32'(4 * i), 32'hA000_0000 | 32'(i), 4'hF, rd, er, lat);
            check($sformatf("l0_st_lat%0d", i), 32'(lat), 32'd0);
        end
        b2b(0);
        vif = d3;
        for (int i = 0; i < 3; i++) begin
            txn(1'b1, 32'h40 + 32'(4 * i), 32'hA000_0300 | 32'(i), 4'hF, rd, er, lat);
            check($sformatf("l3_st_lat%0d", i), 32'(lat), 32'd3);
        end
        b2b(3);

        @(negedge clk);
        d3.rsp_ready = 1'b1;
        d3.req_valid = 1'b1;
        d3.req_write = 1'b0;
        d3.req_addr  = 32'h40;
        @(posedge clk);
        @(negedge clk);
        d3.req_valid = 1'b0;
        check("rw_busy", 32'(busy3), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rw_valid_rst", 32'(d3.rsp_valid), 32'd0);
        check("rw_busy_rst", 32'(busy3), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("rw_ready_rel", 32'(d3.req_ready), 32'd1);
        hits = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (d3.rsp_valid) hits++;
        end
        check("rw_no_spurious", 32'(hits), 32'd0);

        @(negedge clk);
        d0.rsp_ready = 1'b0;
        d0.req_valid = 1'b1;
        d0.req_write = 1'b1;
        d0.req_addr  = 32'h80;
        d0.req_wdata = 32'hCAFEF00D;
        d0.req_be    = 4'hF;
        @(posedge clk);
        @(negedge clk);
        d0.req_valid = 1'b0;
        check("rc_valid", 32'(d0.rsp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rc_valid_rst", 32'(d0.rsp_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        vif = d0;
        txn(1'b0, 32'h80, 32'h0, 4'h0, rd, er, lat);
        check("rc_kept", rd, 32'hCAFEF00D);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
